ahbgpio_arbiter: RTL

AHB-Lite master that shares the AHB GPIO peripheral between two on-chip requesters. Each requester posts a single GPIO operation (write data, write direction, read data, read direction) over a req/done handshake. The block arbitrates round-robin, runs one non-pipelined AHB-Lite transfer at a time to the GPIO register map, and returns read data. It sits between the requester logic and the GPIO slave's HSEL/HADDR/HTRANS port.

---
 rtl/ahbgpio_arb_pkg.sv | 32 +++
 rtl/ahbgpio_arbiter_rr_arb2.sv | 19 +
 rtl/ahbgpio_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ahbgpio_arb_pkg.sv
// rtl/ahbgpio_arb_pkg.sv - shared types and constants for the AHB GPIO arbiter
package ahbgpio_arb_pkg;

  // Transfer sequencing states; encodings are fixed so the state vector stays
  // compatible with older code that compares against raw 2-bit values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Requester operation codes: bit 1 selects read, bit 0 selects the dir register.
  typedef enum logic [1:0] {
    OP_WR_DATA = 2'b00,
    OP_WR_DIR  = 2'b01,
    OP_RD_DATA = 2'b10,
    OP_RD_DIR  = 2'b11
  } gpio_op_e;

  localparam logic [1:0]  HTRANS_IDLE     = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ   = 2'b10;
  localparam logic [31:0] DATA_REG_OFFSET = 32'd0;
  localparam logic [31:0] DIR_REG_OFFSET  = 32'd4;
  localparam logic [2:0]  HSIZE_WORD      = 3'b010;

  // A direction value is legal only as all-input (0) or pin 0 output (1).
  function automatic logic dir_value_ok(input logic [15:0] value);
    return (value == 16'h0000) || (value == 16'h0001);
  endfunction

endpackage

// File: rtl/ahbgpio_arbiter_rr_arb2.sv
// rtl/ahbgpio_arbiter_rr_arb2.sv - combinational two-way round-robin picker
module ahbgpio_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A lone request wins outright; a tie goes to the requester not served last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ahbgpio_arbiter.sv
// rtl/ahbgpio_arbiter.sv - two-requester AHB-Lite master for the GPIO block (option: AHBGPIO_ARB_DIR_CHECK_EN)
module ahbgpio_arbiter
  import ahbgpio_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h5300_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  req,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_wdata,
  output logic [1:0]  done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  arb_state_e  state;
  logic        winner;
  logic        last_grant;
  logic [1:0]  op_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [1:0]  grant;
  logic [1:0]  sel_op;
  logic [15:0] sel_wdata;
  logic        dir_reject;
  logic        unused_hrdata_hi;

  // Only the low half of the slave read bus carries GPIO state.
  assign unused_hrdata_hi = ^HRDATA[31:16];

  ahbgpio_rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign sel_op    = grant[1] ? req_op[3:2]     : req_op[1:0];
  assign sel_wdata = grant[1] ? req_wdata[31:16] : req_wdata[15:0];

`ifdef AHBGPIO_ARB_DIR_CHECK_EN
  logic err_q;

  assign dir_reject = (sel_op == OP_WR_DIR) && !dir_value_ok(sel_wdata);

  // Remember whether the accepted operation was refused without a bus transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_q <= 1'b0;
    end else if (state == ST_IDLE && (|req)) begin
      err_q <= dir_reject;
    end
  end

  assign err = (state == ST_RESP) && err_q;
`else
  assign dir_reject = 1'b0;
  assign err        = 1'b0;
`endif

  // Sequencer: accept a winner in IDLE, run one address and one data phase, then report.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      winner     <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= 2'b00;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            winner  <= grant[1];
            op_q    <= sel_op;
            wdata_q <= sel_wdata;
            rdata_q <= 16'h0000;
            state   <= dir_reject ? ST_RESP : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            rdata_q <= op_q[1] ? HRDATA[15:0] : 16'h0000;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant <= winner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus and requester outputs decode straight from state so reset clears them at once.
  always_comb begin
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    HWDATA = 32'h0;
    done   = 2'b00;
    rdata  = 16'h0000;
    case (state)
      ST_ADDR: begin
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HADDR  = BASE_ADDR + (op_q[0] ? DIR_REG_OFFSET : DATA_REG_OFFSET);
        HWRITE = ~op_q[1];
      end
      ST_DATA: begin
        if (!op_q[1]) begin
          HWDATA = {16'h0000, wdata_q};
        end
      end
      ST_RESP: begin
        done  = winner ? 2'b10 : 2'b01;
        rdata = rdata_q;
      end
      default: ;
    endcase
  end

  assign HSIZE = HSIZE_WORD;

endmodule
